// File: rtl/kamus_pkg.sv
// Shared definitions for the Kamus MEM stage: FSM states,
// funct3 access sizes, writeback mux encodings and alignment check.
package kamus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(logic [2:0] f3, logic [1:0] off);
        return ((f3[1:0] == F3_H[1:0]) && off[0]) ||
               ((f3[1:0] == F3_W[1:0]) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/kamus_load_align.sv
// Load data extraction: picks the byte/half at off_i from the L1D word
// and sign/zero extends per funct3_i. Ports: rdata_i, off_i, funct3_i -> data_o.
module kamus_load_align
    import kamus_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Move the addressed lane down to bit 0.
    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = rdata_i;
        unique case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'd0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'd0, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/kamus_mem_stage.sv
// MEM pipeline stage: issues L1D requests (IDLE/REQ/WAIT), stalls the front
// of the pipe while waiting, and drives the MEM/WB register and misalign pulse.
module kamus_mem_stage
    import kamus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_exmem_reg_i,
    input  logic [31:0] alu_exmem_reg_i,
    input  logic [31:0] rs2_data_exmem_reg_i,
    input  logic        mem_rd_exmem_reg_i,
    input  logic        mem_wr_exmem_reg_i,
    input  logic [2:0]  funct3_exmem_reg_i,
    input  logic        regfile_wr_en_exmem_reg_i,
    input  logic [1:0]  wb_mux_sel_exmem_reg_i,
    input  logic [4:0]  rd_addr_exmem_reg_i,
    output logic        l1d_req_valid_o,
    input  logic        l1d_req_ready_i,
    output logic [31:0] l1d_addr_o,
    output logic        l1d_we_o,
    output logic [31:0] l1d_wdata_o,
    output logic [3:0]  l1d_wstrb_o,
    input  logic        l1d_rsp_valid_i,
    input  logic [31:0] l1d_rd_data_i,
    output logic        regfile_wr_en_memwb_reg_o,
    output logic [31:0] alu_memwb_reg_o,
    output logic [31:0] l1d_rd_data_memwb_reg_o,
    output logic [1:0]  wb_mux_sel_memwb_reg_o,
    output logic [4:0]  rd_addr_memwb_reg_o,
    output logic        stall_o,
    output logic        misalign_o
);

    mem_state_e  state_q, state_d;
    logic        is_mem, mis, start, bad, rsp_done, idle_alu;
    logic [31:0] wdata_d, addr_q, wdata_q, ld_data;
    logic [3:0]  wstrb_d, wstrb_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q, misalign_q;
    logic        wen_q;
    logic [31:0] alu_q, data_q;
    logic [1:0]  sel_q;
    logic [4:0]  rd_q;

    assign is_mem   = valid_exmem_reg_i &&
                      (mem_rd_exmem_reg_i || mem_wr_exmem_reg_i);
    assign mis      = is_misaligned(funct3_exmem_reg_i, alu_exmem_reg_i[1:0]);
    assign start    = (state_q == ST_IDLE) && is_mem && !mis;
    assign bad      = (state_q == ST_IDLE) && is_mem && mis;
    assign idle_alu = (state_q == ST_IDLE) && valid_exmem_reg_i && !is_mem;
    assign rsp_done = (state_q == ST_WAIT) && l1d_rsp_valid_i;

    assign stall_o = start || (state_q == ST_REQ) ||
                     ((state_q == ST_WAIT) && !l1d_rsp_valid_i);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_REQ;
            ST_REQ:  if (l1d_req_ready_i) state_d = ST_WAIT;
            ST_WAIT: if (l1d_rsp_valid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Narrow stores replicate their data across lanes; strobes pick the lane.
    always_comb begin
        wdata_d = rs2_data_exmem_reg_i;
        wstrb_d = 4'b1111;
        unique case (funct3_exmem_reg_i[1:0])
            2'b00: begin
                wdata_d = {4{rs2_data_exmem_reg_i[7:0]}};
                wstrb_d = 4'b0001 << alu_exmem_reg_i[1:0];
            end
            2'b01: begin
                wdata_d = {2{rs2_data_exmem_reg_i[15:0]}};
                wstrb_d = 4'b0011 << alu_exmem_reg_i[1:0];
            end
            default: ;
        endcase
        if (!mem_wr_exmem_reg_i) wstrb_d = 4'b0000;
    end

    kamus_load_align u_align (
        .rdata_i  (l1d_rd_data_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            off_q      <= '0;
            f3_q       <= '0;
            misalign_q <= 1'b0;
            wen_q      <= 1'b0;
            alu_q      <= '0;
            data_q     <= '0;
            sel_q      <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            misalign_q <= bad;
            // Bubble by default; payload fields hold.
            wen_q      <= 1'b0;
            if (start) begin
                addr_q  <= {alu_exmem_reg_i[31:2], 2'b00};
                we_q    <= mem_wr_exmem_reg_i;
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                off_q   <= alu_exmem_reg_i[1:0];
                f3_q    <= funct3_exmem_reg_i;
            end
            // EX/MEM is frozen during the access, so its fields are still valid.
            if (idle_alu || rsp_done) begin
                wen_q  <= regfile_wr_en_exmem_reg_i;
                alu_q  <= alu_exmem_reg_i;
                data_q <= (rsp_done && !we_q) ? ld_data : 32'd0;
                sel_q  <= wb_mux_sel_exmem_reg_i;
                rd_q   <= rd_addr_exmem_reg_i;
            end
        end
    end

    assign l1d_req_valid_o           = (state_q == ST_REQ);
    assign l1d_addr_o                = addr_q;
    assign l1d_we_o                  = we_q;
    assign l1d_wdata_o               = wdata_q;
    assign l1d_wstrb_o               = wstrb_q;
    assign misalign_o                = misalign_q;
    assign regfile_wr_en_memwb_reg_o = wen_q;
    assign alu_memwb_reg_o           = alu_q;
    assign l1d_rd_data_memwb_reg_o   = data_q;
    assign wb_mux_sel_memwb_reg_o    = sel_q;
    assign rd_addr_memwb_reg_o       = rd_q;

endmodule

// File: tb/tb_kamus_mem_stage.sv
// Self-checking bench for kamus_mem_stage: directed scenarios plus
// randomized loads/stores/ALU ops against a byte-level reference model.
module tb_kamus_mem_stage;
    import kamus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mem_rd, mem_wr, wen_in, ready, rsp;
    logic [31:0] alu_in, rs2_in, rdata_in;
    logic [2:0]  f3_in;
    logic [1:0]  sel_in;
    logic [4:0]  rd_in;
    logic        req_valid, we_o, wen_o, stall, misalign;
    logic [31:0] addr_o, wdata_o, alu_o, data_o;
    logic [3:0]  wstrb_o;
    logic [1:0]  sel_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int failures = 0;

    logic        exp_wen;
    logic [31:0] exp_alu, exp_data;
    logic [1:0]  exp_sel;
    logic [4:0]  exp_rd;

    always #5 clk = ~clk;

    kamus_mem_stage dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_n),
        .valid_exmem_reg_i         (valid),
        .alu_exmem_reg_i           (alu_in),
        .rs2_data_exmem_reg_i      (rs2_in),
        .mem_rd_exmem_reg_i        (mem_rd),
        .mem_wr_exmem_reg_i        (mem_wr),
        .funct3_exmem_reg_i        (f3_in),
        .regfile_wr_en_exmem_reg_i (wen_in),
        .wb_mux_sel_exmem_reg_i    (sel_in),
        .rd_addr_exmem_reg_i       (rd_in),
        .l1d_req_valid_o           (req_valid),
        .l1d_req_ready_i           (ready),
        .l1d_addr_o                (addr_o),
        .l1d_we_o                  (we_o),
        .l1d_wdata_o               (wdata_o),
        .l1d_wstrb_o               (wstrb_o),
        .l1d_rsp_valid_i           (rsp),
        .l1d_rd_data_i             (rdata_in),
        .regfile_wr_en_memwb_reg_o (wen_o),
        .alu_memwb_reg_o           (alu_o),
        .l1d_rd_data_memwb_reg_o   (data_o),
        .wb_mux_sel_memwb_reg_o    (sel_o),
        .rd_addr_memwb_reg_o       (rd_o),
        .stall_o                   (stall),
        .misalign_o                (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: accesses as byte counts and lane indices.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic misal(input logic [31:0] a, input logic [2:0] f3);
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd_word,
                                             input logic [31:0] a,
                                             input logic [2:0] f3);
        int s = size_of(f3);
        int off = int'(a[1:0]);
        logic [31:0] v = '0;
        for (int k = 0; k < s; k++) v[8*k +: 8] = rd_word[8*(off+k) +: 8];
        if (!f3[2] && s < 4 && v[8*s-1])
            for (int k = s; k < 4; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d,
                                              input logic [2:0] f3);
        int s = size_of(f3);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % s) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [31:0] a,
                                             input logic [2:0] f3);
        int s = size_of(f3);
        int off = int'(a[1:0]);
        logic [3:0] st;
        for (int k = 0; k < 4; k++) st[k] = (k >= off) && (k < off + s);
        return st;
    endfunction

    task automatic chk_memwb(input string tag);
        chk({tag, "_wen"}, {31'd0, wen_o}, {31'd0, exp_wen});
        chk({tag, "_alu"}, alu_o, exp_alu);
        chk({tag, "_data"}, data_o, exp_data);
        chk({tag, "_sel"}, {30'd0, sel_o}, {30'd0, exp_sel});
        chk({tag, "_rd"}, {27'd0, rd_o}, {27'd0, exp_rd});
    endtask

    task automatic drive(input logic v, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic wen,
                         input logic [4:0] rd);
        valid  = v;
        mem_rd = ld;
        mem_wr = st;
        f3_in  = f3;
        alu_in = a;
        rs2_in = wd;
        wen_in = wen;
        sel_in = ld ? WB_LOAD : WB_ALU;
        rd_in  = rd;
    endtask

    task automatic mem_txn(input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdw, input int rdy_dly,
                           input int rsp_dly, input logic wen,
                           input logic [4:0] rd);
        @(negedge clk);
        drive(1'b1, ld, !ld, f3, a, wd, wen, rd);
        ready = 1'b0;
        rsp   = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd1);
        chk("idle_reqv", {31'd0, req_valid}, 32'd0);
        chk_memwb("idle");
        exp_wen = 1'b0;
        for (int i = 0; i <= rdy_dly; i++) begin
            @(negedge clk);
            ready = (i == rdy_dly);
            #1;
            chk("req_valid", {31'd0, req_valid}, 32'd1);
            chk("req_addr", addr_o, {a[31:2], 2'b00});
            chk("req_we", {31'd0, we_o}, {31'd0, !ld});
            if (!ld) begin
                chk("req_wdata", wdata_o, ref_wdata(wd, f3));
                chk("req_wstrb", {28'd0, wstrb_o}, {28'd0, ref_wstrb(a, f3)});
            end
            chk("req_stall", {31'd0, stall}, 32'd1);
            chk_memwb("req_bub");
        end
        for (int j = 0; j <= rsp_dly; j++) begin
            @(negedge clk);
            ready    = 1'b0;
            rsp      = (j == rsp_dly);
            rdata_in = rsp ? rdw : $urandom;
            #1;
            chk("wait_reqv", {31'd0, req_valid}, 32'd0);
            chk("wait_stall", {31'd0, stall}, {31'd0, j != rsp_dly});
            chk_memwb("wait_bub");
        end
        @(negedge clk);
        rsp = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, $urandom, $urandom, 1'b0, 5'd0);
        #1;
        exp_wen  = wen;
        exp_alu  = a;
        exp_data = ld ? ref_load(rdw, a, f3) : 32'd0;
        exp_sel  = ld ? WB_LOAD : WB_ALU;
        exp_rd   = rd;
        chk_memwb("done");
        chk("done_stall", {31'd0, stall}, 32'd0);
        exp_wen = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] a, input logic wen,
                          input logic [4:0] rd);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 3'($urandom), a, $urandom, wen, rd);
        #1;
        chk("alu_stall", {31'd0, stall}, 32'd0);
        chk_memwb("alu_pre");
        @(negedge clk);
        valid = 1'b0;
        #1;
        exp_wen  = wen;
        exp_alu  = a;
        exp_data = 32'd0;
        exp_sel  = WB_ALU;
        exp_rd   = rd;
        chk_memwb("alu");
        exp_wen = 1'b0;
    endtask

    task automatic misal_op(input logic ld, input logic [2:0] f3,
                            input logic [31:0] a);
        @(negedge clk);
        drive(1'b1, ld, !ld, f3, a, $urandom, 1'b1, 5'd7);
        #1;
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_pre", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_reqv", {31'd0, req_valid}, 32'd0);
        chk_memwb("mis");
        @(negedge clk);
        #1;
        chk("mis_clear", {31'd0, misalign}, 32'd0);
        chk("mis_reqv2", {31'd0, req_valid}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_reqv"}, {31'd0, req_valid}, 32'd0);
        chk({tag, "_addr"}, addr_o, 32'd0);
        chk({tag, "_we"}, {31'd0, we_o}, 32'd0);
        chk({tag, "_wdata"}, wdata_o, 32'd0);
        chk({tag, "_wstrb"}, {28'd0, wstrb_o}, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign}, 32'd0);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk_memwb(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3s [5];
        logic [2:0] f3;
        logic [31:0] a;
        logic ld;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 5'd0);
        ready = 1'b0;
        rsp = 1'b0;
        rdata_in = 32'd0;
        exp_wen = 1'b0;
        exp_alu = '0;
        exp_data = '0;
        exp_sel = '0;
        exp_rd = '0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        mem_txn(1'b1, F3_W, 32'h100, 32'd0, 32'hDEADBEEF, 0, 0, 1'b1, 5'd1);
        chk("lw_lit", data_o, 32'hDEADBEEF);
        mem_txn(1'b1, F3_B, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0, 1'b1, 5'd2);
        chk("lb_lit", data_o, 32'hFFFFFF80);
        mem_txn(1'b1, F3_BU, 32'h103, 32'd0, 32'h80FFFFFF, 0, 0, 1'b1, 5'd3);
        chk("lbu_lit", data_o, 32'h00000080);
        mem_txn(1'b1, F3_HU, 32'h102, 32'd0, 32'h80FFFFFF, 0, 0, 1'b1, 5'd4);
        chk("lhu_lit", data_o, 32'h000080FF);
        mem_txn(1'b0, F3_H, 32'h206, 32'h1234ABCD, 32'd0, 0, 0, 1'b0, 5'd0);
        chk("sh_addr", addr_o, 32'h204);
        chk("sh_wstrb", {28'd0, wstrb_o}, 32'hC);
        chk("sh_wdata", wdata_o, 32'hABCDABCD);
        mem_txn(1'b1, F3_W, 32'h40, 32'd0, 32'h0BADF00D, 3, 2, 1'b1, 5'd9);
        alu_op(32'hCAFE0001, 1'b1, 5'd12);
        misal_op(1'b1, F3_W, 32'h102);

        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, F3_W, 32'h300, 32'd0, 1'b1, 5'd5);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        #1;
        chk("rst_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        exp_wen = 1'b0;
        exp_alu = '0;
        exp_data = '0;
        exp_sel = '0;
        exp_rd = '0;
        chk_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rsp = 1'b1;
        rdata_in = 32'h12345678;
        #1;
        chk("stray_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rsp = 1'b0;
        #1;
        chk_all_zero("stray");

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                alu_op(a, 1'($urandom), 5'($urandom));
            end else begin
                ld = 1'($urandom);
                f3 = ld ? f3s[$urandom_range(0, 4)] : f3s[$urandom_range(0, 2)];
                if (misal(a, f3))
                    misal_op(ld, f3, a);
                else
                    mem_txn(ld, f3, a, $urandom, $urandom,
                            $urandom_range(0, 2), $urandom_range(0, 2),
                            ld ? 1'($urandom) : 1'b0, 5'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
